// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state type, default geometry and chunking check for seq_chunk_adder
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    // A legal geometry splits the operand into a whole number of non-empty chunks.
    function automatic bit chunking_legal(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_add.sv
// rtl/chunk_add.sv - CHUNK-bit combinational add slice with carry in/out
module chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle add/sub, CHUNK bits per clock; flags built when SEQ_ADDER_FLAGS_EN is defined
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(NCH - 1);

    if (!chunking_legal(WIDTH, CHUNK)) begin : g_bad_chunking
        $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    adder_state_t     state_q, state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic             carry_q;
    logic [CW-1:0]    k_q;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_cout;
    logic             last_chunk;

    // One slice serves every chunk; the counter steers which bits it sees.
    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a    (a_q[k_q*CHUNK +: CHUNK]),
        .b    (b_q[k_q*CHUNK +: CHUNK]),
        .cin  (carry_q),
        .s    (chunk_s),
        .cout (chunk_cout)
    );

    assign last_chunk = (k_q == K_LAST);

    always_comb begin
        res_next = res_q;
        res_next[k_q*CHUNK +: CHUNK] = chunk_s;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B once and seed the carry.
                        a_q     <= in_1;
                        b_q     <= sub ? ~in_2 : in_2;
                        carry_q <= sub;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    res_q   <= res_next;
                    carry_q <= chunk_cout;
                    k_q     <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum_out = res_q;

`ifdef SEQ_ADDER_FLAGS_EN
    logic carry_f;
    logic overflow_f;
    logic zero_f;

    // Flags are captured from the final chunk so they line up with the full result.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_f    <= 1'b0;
            overflow_f <= 1'b0;
            zero_f     <= 1'b0;
        end else if ((state_q == RUN) && last_chunk) begin
            carry_f    <= chunk_cout;
            overflow_f <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
            zero_f     <= (res_next == '0);
        end
    end

    assign carry_out = carry_f;
    assign overflow  = overflow_f;
    assign zero      = zero_f;
`else
    assign carry_out = 1'b0;
    assign overflow  = 1'b0;
    assign zero      = 1'b0;
`endif

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder/subtractor for the RISC-V datapath that processes a WIDTH-bit operation CHUNK bits per clock. Operands enter through a valid/ready handshake; the result and optional flags leave through a second valid/ready handshake. It sits where the combinational 32-bit adder sits today. It serves address and ALU paths that can tolerate latency in exchange for a short carry chain.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK
- CHUNK, 8, bits added per cycle; NCH = WIDTH/CHUNK chunks per operation
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operands and mode are valid
- in_ready  out  1  block accepts operands this cycle
- in_1  in  WIDTH  operand A
- in_2  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A-B
- out_valid  out  1  result is valid
- out_ready  in  1  consumer takes the result this cycle
- sum_out  out  WIDTH  result
- carry_out  out  1  final carry; for sub, 1 = no borrow
- overflow  out  1  signed overflow
- zero  out  1  sum_out == 0

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - in_valid latches A, B' = sub ? ~in_2 : in_2, and carry = sub; clears the chunk counter; moves to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle adds chunk k of A, B' and carry, then writes sum bits [k*CHUNK +: CHUNK] into the result register.
  - Registers the chunk carry and increments k.
  - After chunk NCH-1, moves to DONE.
- DONE:
  - out_valid = 1; in_ready = 0; result and flags are held stable.
  - out_ready = 1 moves to IDLE.
  - A new operation may be accepted no earlier than the following cycle.
- Arithmetic is modulo 2^WIDTH.
- overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
- zero is evaluated on the full WIDTH result.
- in_valid is ignored outside IDLE. in_1, in_2 and sub may change freely after acceptance.
- Reset at any time: state = IDLE, counter = 0, in-flight operation discarded.
- Reset values: in_ready = 0 during reset and 1 in the first cycle after it; out_valid = 0; sum_out = 0; carry_out = 0; overflow = 0; zero = 0.

## Timing
- Operand accepted at edge T; out_valid rises after edge T+NCH. The default latency is 4 cycles.
- Minimum issue interval: NCH+2 cycles (accept, NCH RUN cycles, one DONE cycle, return to IDLE).
- CHUNK == WIDTH is legal: one RUN cycle, latency 1.
- out_valid stays high until a cycle in which out_ready = 1. Outputs do not change while out_valid && !out_ready.

## Configuration
- SEQ_ADDER_FLAGS_EN defined:
  - carry_out, overflow and zero are computed and registered as above.
- SEQ_ADDER_FLAGS_EN undefined:
  - The flag ports remain and are tied to 0.
  - No flag logic is generated.
  - sum_out and timing are unchanged.

## Structure
- Shared package adder_pkg:
  - FSM state typedef (IDLE/RUN/DONE).
  - Default WIDTH/CHUNK constants.
  - Elaboration-time check that WIDTH % CHUNK == 0.
- One sub-module chunk_add:
  - CHUNK-bit combinational slice; inputs a, b, cin; outputs s, cout.
  - Instantiated once and reused every RUN cycle.
- Counter width is $clog2(NCH), minimum 1.

## Test plan
- Unsigned wrap: 32'h0000_0001 + 32'hFFFF_FFFF -> sum_out 0, carry_out 1, zero 1, overflow 0; out_valid exactly 4 cycles after accept.
- Subtract with borrow: 5 - 7 -> sum_out 32'hFFFF_FFFE, carry_out 0, overflow 0, zero 0.
- Signed overflow: 32'h7FFF_FFFF + 1 -> sum_out 32'h8000_0000, overflow 1, carry_out 0.
- Backpressure: hold out_ready low for 3 cycles in DONE -> outputs stable, in_ready 0, in_valid pulses ignored. out_ready high -> IDLE next cycle and the next operation is accepted.
- Mid-operation reset: assert rst in the 2nd RUN cycle -> next cycle out_valid 0, sum_out 0; in_ready 1 once rst is released; the next operation 3 + 4 = 7 completes correctly.
- Parameter sweep: WIDTH=16, CHUNK=16 -> latency 1; 16'hFFFF + 1 -> sum 0, carry_out 1. Repeat a directed and random set with SEQ_ADDER_FLAGS_EN undefined -> flags always 0, sums identical.
